// File: rtl/prol16_mem_responder_pkg.sv
// prol16_mem_responder_pkg: shared bus widths and responder FSM encodings.
package prol16_mem_responder_pkg;
    localparam int gDataWidth   = 16;
    localparam int gMemAddrBits = 10;
    localparam int gCntWidth    = 16;
    typedef logic [gDataWidth-1:0] data_v;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;
endpackage

// File: rtl/prol16_sat_counter.sv
// prol16_sat_counter: synchronous-clear counter that sticks at its maximum value.
module prol16_sat_counter #(
    parameter int gWidth = 16
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [gWidth-1:0] cnt_o
);
    logic [gWidth-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/prol16_mem_responder.sv
// prol16_mem_responder: word RAM answering the Prol16 memory strobes, with preload port,
// saturating access counters, sticky error flags and a halt freeze.
module prol16_mem_responder
    import prol16_mem_responder_pkg::*;
#(
    parameter int gDataWidth = prol16_mem_responder_pkg::gDataWidth,
    parameter int gAddrBits  = gMemAddrBits,
    parameter int gCntWidth  = prol16_mem_responder_pkg::gCntWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [gDataWidth-1:0] mem_addr_i,
    input  logic [gDataWidth-1:0] mem_wdata_i,
    output logic [gDataWidth-1:0] mem_rdata_o,
    input  logic                  mem_ce_ni,
    input  logic                  mem_oe_ni,
    input  logic                  mem_we_ni,
    input  logic                  cpu_halt_i,
    input  logic                  load_en_i,
    input  logic [gAddrBits-1:0]  load_addr_i,
    input  logic [gDataWidth-1:0] load_data_i,
    output logic [gCntWidth-1:0]  rd_count_o,
    output logic [gCntWidth-1:0]  wr_count_o,
    output logic                  proto_err_o,
    output logic                  range_err_o,
    output logic                  halted_o
);
    logic [gDataWidth-1:0] mem_q [2**gAddrBits];
    logic [gDataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]            state_q, state_d;
    logic                  proto_q, proto_d, range_q, range_d;
    logic                  active, is_rd, is_wr, is_both, in_range;
    logic [gAddrBits-1:0]  idx;
    assign idx      = mem_addr_i[gAddrBits-1:0];
    assign in_range = mem_addr_i[gDataWidth-1:gAddrBits] == '0;
    // a halt arriving with a strobe wins: the access is ignored
    assign active  = !mem_ce_ni && state_q != HALTED && !cpu_halt_i && !rst;
    assign is_rd   = active && !mem_oe_ni && mem_we_ni;
    assign is_wr   = active && mem_oe_ni && !mem_we_ni;
    assign is_both = active && !mem_oe_ni && !mem_we_ni;
    always_comb begin
        state_d = rst ? IDLE
                : (state_q == HALTED || cpu_halt_i) ? HALTED
                : is_rd ? READ : is_wr ? WRITE : IDLE;
        rdata_d = rst ? '0 : is_rd ? (in_range ? mem_q[idx] : '0) : rdata_q;
        proto_d = !rst && (proto_q || is_both);
        range_d = !rst && (range_q || ((is_rd || is_wr) && !in_range));
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        rdata_q <= rdata_d;
        proto_q <= proto_d;
        range_q <= range_d;
    end
    // preload and CPU write share the array; preload takes a colliding address
    always_ff @(posedge clk) begin
        if (load_en_i) mem_q[load_addr_i] <= load_data_i;
        if (is_wr && in_range && !(load_en_i && load_addr_i == idx)) mem_q[idx] <= mem_wdata_i;
    end
    prol16_sat_counter #(.gWidth(gCntWidth)) u_rd_cnt (
        .clk(clk), .clr_i(rst), .inc_i(is_rd), .cnt_o(rd_count_o)
    );
    prol16_sat_counter #(.gWidth(gCntWidth)) u_wr_cnt (
        .clk(clk), .clr_i(rst), .inc_i(is_wr), .cnt_o(wr_count_o)
    );
    assign mem_rdata_o = rdata_q;
    assign proto_err_o = proto_q;
    assign range_err_o = range_q;
    assign halted_o    = state_q == HALTED;
endmodule

// File: tb/tb_prol16_mem_responder.sv
// tb_prol16_mem_responder: directed vectors against hand-computed values for the memory responder.
module tb_prol16_mem_responder;
    logic        clk = 0, rst = 1;
    logic [15:0] mem_addr_i = 0, mem_wdata_i = 0, load_data_i = 0;
    logic [15:0] mem_rdata_o, rd_count_o, wr_count_o;
    logic        mem_ce_ni = 1, mem_oe_ni = 1, mem_we_ni = 1, cpu_halt_i = 0, load_en_i = 0;
    logic [9:0]  load_addr_i = 0;
    logic        proto_err_o, range_err_o, halted_o;
    int          n_chk = 0, n_fail = 0;

    prol16_mem_responder dut (
        .clk(clk), .rst(rst), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ce_ni(mem_ce_ni), .mem_oe_ni(mem_oe_ni),
        .mem_we_ni(mem_we_ni), .cpu_halt_i(cpu_halt_i), .load_en_i(load_en_i),
        .load_addr_i(load_addr_i), .load_data_i(load_data_i), .rd_count_o(rd_count_o),
        .wr_count_o(wr_count_o), .proto_err_o(proto_err_o), .range_err_o(range_err_o),
        .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_ce_ni = 1; mem_oe_ni = 1; mem_we_ni = 1; load_en_i = 0;
    endtask

    task automatic do_rst();
        idle(); rst = 1; cyc(); rst = 0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        idle(); load_en_i = 1; load_addr_i = a; load_data_i = d; cyc(); load_en_i = 0;
    endtask

    task automatic set_rd(input logic [15:0] a);
        mem_ce_ni = 0; mem_oe_ni = 0; mem_we_ni = 1; mem_addr_i = a;
    endtask

    task automatic set_wr(input logic [15:0] a, input logic [15:0] d);
        mem_ce_ni = 0; mem_oe_ni = 1; mem_we_ni = 0; mem_addr_i = a; mem_wdata_i = d;
    endtask

    initial begin
        #1;
        cyc(); cyc(); rst = 0;
        check_eq("rst_rdata", mem_rdata_o, 0);
        check_eq("rst_rd", rd_count_o, 0);
        check_eq("rst_wr", wr_count_o, 0);
        check_eq("rst_flags", {proto_err_o, range_err_o, halted_o}, 0);

        preload(10'h005, 16'hBEEF);
        set_rd(16'h0005); cyc(); idle();
        check_eq("rd_preload", mem_rdata_o, 16'hBEEF);
        check_eq("rd_cnt1", rd_count_o, 1);

        do_rst();
        set_wr(16'h0010, 16'h1234); cyc();
        set_rd(16'h0010); cyc(); idle();
        check_eq("rd_after_wr", mem_rdata_o, 16'h1234);
        check_eq("wr_cnt1", wr_count_o, 1);
        check_eq("rd_cnt_wr", rd_count_o, 1);
        cyc();
        check_eq("rdata_held", mem_rdata_o, 16'h1234);

        do_rst();
        preload(10'h020, 16'h5555);
        mem_ce_ni = 0; mem_oe_ni = 0; mem_we_ni = 0; mem_addr_i = 16'h0020; mem_wdata_i = 16'hDEAD;
        cyc(); idle();
        check_eq("proto_set", proto_err_o, 1);
        check_eq("proto_cnt", {rd_count_o, wr_count_o}, 0);
        cyc();
        check_eq("proto_sticky", proto_err_o, 1);
        set_rd(16'h0020); cyc(); idle();
        check_eq("proto_nowrite", mem_rdata_o, 16'h5555);

        do_rst();
        check_eq("proto_clr", proto_err_o, 0);
        set_rd(16'h0005); cyc();
        check_eq("range_clean", range_err_o, 0);
        set_rd(16'h0400); cyc(); idle();
        check_eq("range_set", range_err_o, 1);
        check_eq("range_rdata", mem_rdata_o, 0);
        check_eq("range_rdcnt", rd_count_o, 2);
        preload(10'h000, 16'h1111);
        set_wr(16'h8000, 16'h7777); cyc(); idle();
        check_eq("range_wrcnt", wr_count_o, 1);
        set_rd(16'h0000); cyc(); idle();
        check_eq("range_dropped", mem_rdata_o, 16'h1111);

        do_rst();
        set_wr(16'h0031, 16'hBBBB); load_en_i = 1; load_addr_i = 10'h030; load_data_i = 16'hAAAA;
        cyc(); idle();
        set_rd(16'h0030); cyc();
        check_eq("dual_preload", mem_rdata_o, 16'hAAAA);
        set_rd(16'h0031); cyc(); idle();
        check_eq("dual_cpu", mem_rdata_o, 16'hBBBB);
        set_wr(16'h0040, 16'hDDDD); load_en_i = 1; load_addr_i = 10'h040; load_data_i = 16'hCCCC;
        cyc(); idle();
        set_rd(16'h0040); cyc(); idle();
        check_eq("collide_preload_wins", mem_rdata_o, 16'hCCCC);

        preload(10'h050, 16'h0101);
        set_wr(16'h0050, 16'h9999); rst = 1; cyc(); rst = 0; idle();
        check_eq("rst_abort_cnt", wr_count_o, 0);
        set_rd(16'h0050); cyc(); idle();
        check_eq("rst_abort_data", mem_rdata_o, 16'h0101);

        do_rst();
        set_rd(16'h0005); cyc();
        check_eq("pre_halt_rd", mem_rdata_o, 16'hBEEF);
        set_rd(16'h0010); cpu_halt_i = 1; cyc(); cpu_halt_i = 0;
        check_eq("halt_set", halted_o, 1);
        check_eq("halt_rdata", mem_rdata_o, 16'hBEEF);
        check_eq("halt_rdcnt", rd_count_o, 1);
        set_rd(16'h0010); cyc(); idle();
        check_eq("halt_sticky", halted_o, 1);
        check_eq("halt_frozen", mem_rdata_o, 16'hBEEF);
        check_eq("halt_rdcnt2", rd_count_o, 1);
        preload(10'h005, 16'h4242);
        do_rst();
        check_eq("halt_clr", halted_o, 0);
        check_eq("halt_cnt_clr", rd_count_o, 0);
        set_rd(16'h0005); cyc(); idle();
        check_eq("halt_preload", mem_rdata_o, 16'h4242);

        do_rst();
        set_rd(16'h0005);
        repeat (65534) cyc();
        check_eq("sat_below", rd_count_o, 16'hFFFE);
        cyc();
        check_eq("sat_max", rd_count_o, 16'hFFFF);
        cyc(); idle();
        check_eq("sat_hold", rd_count_o, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
